// File: rtl/modmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : modmul_arbiter
// Purpose  : Shared-resource controller for one Barrett modular multiplier.
//            Holds the modulus configuration (q, mu, k), grants round-robin
//            between two operand requesters, drives the multiplier operands,
//            waits LATENCY cycles for the result and returns it, tagged with
//            the requester id, on a response channel with backpressure.
// Ports    : clk, rst (sync, active-high)
//            cfg_we/cfg_q/cfg_mu/cfg_k -> cfg_ready      config write
//            reqN_valid/reqN_a/reqN_b  -> reqN_ready     operand requests
//            rsp_valid/rsp_id/rsp_t/rsp_err <- rsp_ready response channel
//            dp_a/dp_b/dp_q/dp_mu/dp_k -> multiplier, dp_t <- multiplier
//            busy                                       controller not idle
// Options  : MODMUL_ARB_RANGE_CHECK_EN - when defined, operands >= q are
//            rejected with rsp_err = 1 one cycle after the accept.
// Revision : 1.0 - initial release
// ============================================================================
module modmul_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [63:0] cfg_q,
    input  logic [30:0] cfg_mu,
    input  logic [7:0]  cfg_k,
    output logic        cfg_ready,
    input  logic        req0_valid,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic        req1_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_t,
    output logic        rsp_err,
    output logic [63:0] dp_a,
    output logic [63:0] dp_b,
    output logic [63:0] dp_q,
    output logic [30:0] dp_mu,
    output logic [7:0]  dp_k,
    input  logic [63:0] dp_t,
    output logic        busy
);

    localparam logic [7:0] c_latency = 8'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state_q,  w_state_d;
    logic [63:0] r_modq_q,   w_modq_d;
    logic [30:0] r_mu_q,     w_mu_d;
    logic [7:0]  r_k_q,      w_k_d;
    logic        r_loaded_q, w_loaded_d;
    logic        r_last_q,   w_last_d;
    logic [63:0] r_dpa_q,    w_dpa_d;
    logic [63:0] r_dpb_q,    w_dpb_d;
    logic        r_id_q,     w_id_d;
    logic [7:0]  r_cnt_q,    w_cnt_d;
    logic [63:0] r_rspt_q,   w_rspt_d;

    logic        w_idle;
    logic        w_gnt_valid;
    logic        w_gnt;
    logic        w_acc;
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic        w_range_err;

    assign w_idle = (r_state_q == ST_IDLE);

    // Round-robin: a lone requester always wins; on a tie the requester that
    // did not get the previous grant wins.
    assign w_gnt_valid = r_loaded_q && (req0_valid || req1_valid);
    assign w_gnt       = (req0_valid && req1_valid) ? ~r_last_q : req1_valid;
    assign req0_ready  = w_idle && w_gnt_valid && !w_gnt;
    assign req1_ready  = w_idle && w_gnt_valid &&  w_gnt;
    assign w_acc       = req0_ready || req1_ready;
    assign w_a         = w_gnt ? req1_a : req0_a;
    assign w_b         = w_gnt ? req1_b : req0_b;

`ifdef MODMUL_ARB_RANGE_CHECK_EN
    logic r_err_q, w_err_d;

    // Compared against the modulus in force at the accept edge.
    assign w_range_err = (w_a >= r_modq_q) || (w_b >= r_modq_q);

    always_comb begin
        w_err_d = r_err_q;
        if (w_idle && w_acc) begin
            w_err_d = w_range_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_q <= 1'b0;
        end else begin
            r_err_q <= w_err_d;
        end
    end

    assign rsp_err = r_err_q;
`else
    assign w_range_err = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_comb begin
        w_state_d  = r_state_q;
        w_modq_d   = r_modq_q;
        w_mu_d     = r_mu_q;
        w_k_d      = r_k_q;
        w_loaded_d = r_loaded_q;
        w_last_d   = r_last_q;
        w_dpa_d    = r_dpa_q;
        w_dpb_d    = r_dpb_q;
        w_id_d     = r_id_q;
        w_cnt_d    = r_cnt_q;
        w_rspt_d   = r_rspt_q;

        // A zero modulus is meaningless, so such a write is dropped. The
        // accept decision above already used the old loaded flag.
        if (cfg_we && w_idle && (cfg_q != 64'd0)) begin
            w_modq_d   = cfg_q;
            w_mu_d     = cfg_mu;
            w_k_d      = cfg_k;
            w_loaded_d = 1'b1;
        end

        case (r_state_q)
            ST_IDLE: begin
                if (w_acc) begin
                    w_last_d = w_gnt;
                    w_id_d   = w_gnt;
                    if (w_range_err) begin
                        // Out-of-range operands never reach the multiplier.
                        w_rspt_d  = 64'd0;
                        w_state_d = ST_RESP;
                    end else begin
                        w_dpa_d   = w_a;
                        w_dpb_d   = w_b;
                        w_cnt_d   = c_latency;
                        w_state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_d = r_cnt_q - 8'd1;
                if (r_cnt_q == 8'd1) begin
                    w_rspt_d  = dp_t;
                    w_state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_modq_q   <= 64'd0;
            r_mu_q     <= 31'd0;
            r_k_q      <= 8'd0;
            r_loaded_q <= 1'b0;
            r_last_q   <= 1'b1;
            r_dpa_q    <= 64'd0;
            r_dpb_q    <= 64'd0;
            r_id_q     <= 1'b0;
            r_cnt_q    <= 8'd0;
            r_rspt_q   <= 64'd0;
        end else begin
            r_state_q  <= w_state_d;
            r_modq_q   <= w_modq_d;
            r_mu_q     <= w_mu_d;
            r_k_q      <= w_k_d;
            r_loaded_q <= w_loaded_d;
            r_last_q   <= w_last_d;
            r_dpa_q    <= w_dpa_d;
            r_dpb_q    <= w_dpb_d;
            r_id_q     <= w_id_d;
            r_cnt_q    <= w_cnt_d;
            r_rspt_q   <= w_rspt_d;
        end
    end

    assign cfg_ready = w_idle;
    assign rsp_valid = (r_state_q == ST_RESP);
    assign busy      = !w_idle;
    assign rsp_id    = r_id_q;
    assign rsp_t     = r_rspt_q;
    assign dp_a      = r_dpa_q;
    assign dp_b      = r_dpb_q;
    assign dp_q      = r_modq_q;
    assign dp_mu     = r_mu_q;
    assign dp_k      = r_k_q;

endmodule
`default_nettype wire

// File: doc/modmul_arbiter.md
# modmul_arbiter

Shared-resource controller for the single Barrett modular multiplier instance (`karatsuba_barrett`). It holds the modulus configuration (q, mu, k), arbitrates round-robin between two operand requesters with valid/ready handshakes, and drives the multiplier's operand ports. It waits a fixed settle latency and returns the tagged result on a response channel with backpressure. It sits between the NTT/polynomial front ends and the multiplier datapath.

## Interface
- `LATENCY`, default 4: cycles `dp_t` needs to be valid after the `dp_*` operands change; legal values are 1..255.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  modulus config write strobe.
- `cfg_q`  in  64  modulus q.
- `cfg_mu`  in  31  Barrett constant mu.
- `cfg_k`  in  8  Barrett shift k.
- `cfg_ready`  out  1  config write is accepted this cycle.
- `req0_valid`, `req1_valid`  in  1  operand request from requester 0 / 1.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  64  operands.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  1  index of the requester that owns the response.
- `rsp_t`  out  64  result, a·b mod q.
- `rsp_err`  out  1  operand range error (macro-dependent, see Configuration).
- `dp_a`, `dp_b`, `dp_q`  out  64  multiplier operands and modulus.
- `dp_mu`  out  31  multiplier mu.
- `dp_k`  out  8  multiplier k.
- `dp_t`  in  64  multiplier result.
- `busy`  out  1  the controller is not in IDLE.

## Operation
- **Config registers.** q, mu and k are held in registers, and `cfg_loaded` is a flag.
  - `cfg_ready` = (state == IDLE).
  - A write with `cfg_we && cfg_ready && cfg_q != 0` loads all three registers and sets `cfg_loaded`.
  - A write with `cfg_q == 0` is ignored.
- **Operand and config outputs.** `dp_q`, `dp_mu` and `dp_k` always reflect the config registers. `dp_a` and `dp_b` are registered operand latches.
- **FSM states.** IDLE, WAIT, RESP.
- **IDLE.**
  - When `cfg_loaded` is set, the round-robin grant selects the requester with valid asserted.
  - If both requesters are valid, the grant goes to the one that is not `last_grant`.
  - `reqN_ready` is combinational: IDLE && `cfg_loaded` && grant == N. At most one ready is high per cycle.
  - On the handshake, the controller latches a and b into `dp_a`/`dp_b`, latches the id, loads `cnt` = LATENCY, sets `last_grant` = N, and goes to WAIT.
  - While `cfg_loaded` = 0, both readies stay low.
- **WAIT.**
  - `cnt` decrements by one each cycle.
  - When `cnt == 1`, the controller captures `dp_t` into `rsp_t`, sets `rsp_err` = 0, and goes to RESP.
- **RESP.**
  - `rsp_valid` = 1, and `rsp_id`, `rsp_t` and `rsp_err` are held stable.
  - On `rsp_ready`, the controller returns to IDLE.
  - A new request can be accepted in the IDLE cycle that follows. There is no issue in the same cycle as the response handshake.
- **Simultaneous config write and request in IDLE.** The config write takes effect, but the request is evaluated against the old `cfg_loaded`. The operands are issued, and `dp_q`, `dp_mu` and `dp_k` carry the new values from the next cycle on.
- **Reset (including mid-operation).**
  - State goes to IDLE and any in-flight response is dropped.
  - `cfg_loaded` = 0, `last_grant` = 1 (so requester 0 wins the first tie), and `cnt` = 0.
  - All config registers, `dp_*`, `rsp_t`, `rsp_id` and `rsp_err` = 0.
  - `rsp_valid`, `busy`, and both `reqN_ready` = 0.

## Timing
- **Accept-to-response latency.** If the request is accepted at edge E, `rsp_valid` is high after edge E+LATENCY. With LATENCY = 4, a request accepted at edge 0 gives `rsp_valid` visible after edge 4.
- **Minimum issue interval.** The interval is LATENCY+2 cycles when `rsp_ready` is held high.
- **Operand and config stability.** `dp_a` and `dp_b` change only on an accept edge. `dp_q`, `dp_mu` and `dp_k` change only on a config load, and config loads happen only in IDLE. The datapath inputs are therefore stable throughout WAIT and RESP.
- **Response backpressure.** `rsp_valid` stays high for as long as `rsp_ready` is low. No response is ever lost or overwritten.

## Configuration
- `MODMUL_ARB_RANGE_CHECK_EN` defined:
  - In IDLE, the accepted operands are compared against q.
  - If a ≥ q or b ≥ q, the request is still handshaken. The controller skips WAIT and goes directly to RESP with `rsp_err` = 1 and `rsp_t` = 0.
  - In this case `dp_a`/`dp_b` are not updated, and the result is returned 1 cycle after the accept.
- `MODMUL_ARB_RANGE_CHECK_EN` undefined:
  - No comparators are present and `rsp_err` is a constant 0.
  - Every request takes the WAIT path.

## Test plan
- **Reset.** Assert `rst` for 3 cycles with `req0_valid` = 1 → all outputs are 0, no ready, no response.
- **Single request.** Load q = 768112, mu = 1431447, k = 20. Send req0 a = 146712, b = 248912 with LATENCY = 4 → `req0_ready` on the first IDLE cycle; `rsp_valid` after 4 edges with `rsp_id` = 0, `rsp_t` = 28528, `rsp_err` = 0.
- **Contention.** Hold both `req0_valid` and `req1_valid` for 4 transactions with `rsp_ready` = 1 → grant order is 0, 1, 0, 1, and the issue interval is 6 cycles.
- **Backpressure and stability.** Hold `rsp_ready` low for 10 cycles, then pulse a config write with `cfg_q` = 97 during RESP → `rsp_valid` and `rsp_t` stay stable, `cfg_ready` = 0, and `dp_q` is still 768112.
- **Reset mid-WAIT.** Assert `rst` two cycles after an accept → no response appears, `cfg_loaded` = 0, and a subsequent request is not accepted until the config is reloaded.
- **Range check.** With `MODMUL_ARB_RANGE_CHECK_EN` defined, send a = 768112 → response 1 cycle after accept with `rsp_err` = 1 and `rsp_t` = 0. Without the macro, the same request gives a normal LATENCY-cycle response with `rsp_err` = 0.
